// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths and load-type encodings shared by the MEM stage.
// Optional feature macro: MEM_FWD_EN (adds the ms_fwd_zip forwarding port).
package mem_stage_pkg;
    localparam int ES2MS_BUS_W = 74;
    localparam int MS2WS_BUS_W = 70;
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects and extends the byte/halfword addressed by a load.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = addr == 2'd0 ? word[7:0]   :
                    addr == 2'd1 ? word[15:8]  :
                    addr == 2'd2 ? word[23:16] : word[31:24];
    assign w_half = addr[1] ? word[31:16] : word[15:0];
    // Unknown ld_type codes fall through to a whole-word load.
    assign result = ld_type == LD_B  ? {{24{w_byte[7]}}, w_byte}  :
                    ld_type == LD_BU ? {24'd0, w_byte}            :
                    ld_type == LD_H  ? {{16{w_half[15]}}, w_half} :
                    ld_type == LD_HU ? {16'd0, w_half}            : word;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; holds the EX bundle, keeps the SRAM word across WB stalls,
// aligns load data and drives the WB bundle. Define MEM_FWD_EN to add the ms_fwd_zip port.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es2ms_valid,
    output logic                   ms_allowin,
    input  logic [ES2MS_BUS_W-1:0] es2ms_bus,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allowin,
    output logic                   ms2ws_valid,
    output logic [MS2WS_BUS_W-1:0] ms2ws_bus,
    output logic                   ms_valid,
    output logic                   gr_we_reg,
    output logic [4:0]             dest_reg,
    output logic                   ms_res_from_mem
`ifdef MEM_FWD_EN
    ,output logic [37:0]           ms_fwd_zip
`endif
);
    logic                   r_ms_valid;
    logic                   r_first;
    logic [31:0]            r_rbuf;
    logic [ES2MS_BUS_W-1:0] r_bus;
    logic [31:0]            w_pc;
    logic [2:0]             w_ld_type;
    logic [31:0]            w_alu_result;
    logic [31:0]            w_word;
    logic [31:0]            w_aligned;
    logic [31:0]            w_final;

    assign w_pc            = r_bus[73:42];
    assign gr_we_reg       = r_bus[41];
    assign dest_reg        = r_bus[40:36];
    assign ms_res_from_mem = r_bus[35];
    assign w_ld_type       = r_bus[34:32];
    assign w_alu_result    = r_bus[31:0];

    assign ms_valid    = r_ms_valid;
    assign ms_allowin  = ~r_ms_valid | ws_allowin;
    assign ms2ws_valid = r_ms_valid;

    // The SRAM word is only valid in the first cycle; afterwards use the captured copy.
    assign w_word = r_first ? data_sram_rdata : r_rbuf;

    mem_load_align u_align (
        .ld_type (w_ld_type),
        .addr    (w_alu_result[1:0]),
        .word    (w_word),
        .result  (w_aligned)
    );

    assign w_final   = ms_res_from_mem ? w_aligned : w_alu_result;
    assign ms2ws_bus = {w_pc, gr_we_reg, dest_reg, w_final};
`ifdef MEM_FWD_EN
    assign ms_fwd_zip = {r_ms_valid & gr_we_reg, dest_reg, w_final};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
            r_first    <= 1'b0;
            r_rbuf     <= '0;
            r_bus      <= '0;
        end else begin
            if (ms_allowin)
                r_ms_valid <= es2ms_valid;
            if (es2ms_valid && ms_allowin) begin
                r_bus   <= es2ms_bus;
                r_first <= 1'b1;
            end else begin
                r_first <= 1'b0;
            end
            if (r_first && r_ms_valid && !ws_allowin)
                r_rbuf <= data_sram_rdata;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        es2ms_valid;
    logic        ms_allowin;
    logic [73:0] es2ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms2ws_valid;
    logic [69:0] ms2ws_bus;
    logic        ms_valid;
    logic        gr_we_reg;
    logic [4:0]  dest_reg;
    logic        ms_res_from_mem;
`ifdef MEM_FWD_EN
    logic [37:0] ms_fwd_zip;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .es2ms_valid     (es2ms_valid),
        .ms_allowin      (ms_allowin),
        .es2ms_bus       (es2ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms2ws_valid     (ms2ws_valid),
        .ms2ws_bus       (ms2ws_bus),
        .ms_valid        (ms_valid),
        .gr_we_reg       (gr_we_reg),
        .dest_reg        (dest_reg),
        .ms_res_from_mem (ms_res_from_mem)
`ifdef MEM_FWD_EN
        ,.ms_fwd_zip     (ms_fwd_zip)
`endif
    );

    function automatic logic [73:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                       input logic rfm, input logic [2:0] ld, input logic [31:0] alu);
        return {pc, we, dest, rfm, ld, alu};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b1; es2ms_valid = 1'b0; es2ms_bus = '0; data_sram_rdata = 32'hFFFF_FFFF; ws_allowin = 1'b1;
        tick; tick;
        reset = 1'b0;
        #1;
        n_tests++; if (ms_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ms_valid got %h exp 0", ms_valid); end
        n_tests++; if (ms2ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ms2ws_valid got %h exp 0", ms2ws_valid); end
        n_tests++; if (gr_we_reg !== 1'b0) begin n_fail++; $display("FAIL reset_gr_we got %h exp 0", gr_we_reg); end
        n_tests++; if (dest_reg !== 5'd0) begin n_fail++; $display("FAIL reset_dest got %h exp 0", dest_reg); end
        n_tests++; if (ms_res_from_mem !== 1'b0) begin n_fail++; $display("FAIL reset_rfm got %h exp 0", ms_res_from_mem); end
        n_tests++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %h exp 1", ms_allowin); end
        n_tests++; if (ms2ws_bus !== 70'd0) begin n_fail++; $display("FAIL reset_bus got %h exp 0", ms2ws_bus); end
    endtask

    task automatic test_load_byte;
        es2ms_valid = 1'b1; es2ms_bus = mk(32'h100, 1'b1, 5'd3, 1'b1, LD_B, 32'h0000_1003); data_sram_rdata = 32'h0;
        tick;
        es2ms_valid = 1'b0; data_sram_rdata = 32'h80FF_1234;
        #1;
        n_tests++; if (ms2ws_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_valid got %h exp 1", ms2ws_valid); end
        n_tests++; if (ms2ws_bus[31:0] !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_result got %h exp ffffff80", ms2ws_bus[31:0]); end
        n_tests++; if (ms2ws_bus[37] !== 1'b1) begin n_fail++; $display("FAIL ldb_gr_we got %h exp 1", ms2ws_bus[37]); end
        n_tests++; if (ms2ws_bus[69:38] !== 32'h100) begin n_fail++; $display("FAIL ldb_pc got %h exp 100", ms2ws_bus[69:38]); end
        n_tests++; if (dest_reg !== 5'd3 || ms_res_from_mem !== 1'b1) begin n_fail++; $display("FAIL ldb_hazard got %h/%h exp 3/1", dest_reg, ms_res_from_mem); end
        tick;
        #1;
        n_tests++; if (ms_valid !== 1'b0) begin n_fail++; $display("FAIL drain_ms_valid got %h exp 0", ms_valid); end
    endtask

    task automatic test_stall_hold;
        es2ms_valid = 1'b1; es2ms_bus = mk(32'h104, 1'b1, 5'd7, 1'b1, LD_HU, 32'h0000_2002); ws_allowin = 1'b1;
        tick;
        es2ms_bus = mk(32'h108, 1'b1, 5'd9, 1'b0, LD_W, 32'h1234_5678);
        ws_allowin = 1'b0; data_sram_rdata = 32'h9ABC_0000;
        #1;
        n_tests++; if (ms2ws_bus[31:0] !== 32'h0000_9ABC) begin n_fail++; $display("FAIL hu_first got %h exp 00009abc", ms2ws_bus[31:0]); end
        n_tests++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_allowin got %h exp 0", ms_allowin); end
        for (int i = 0; i < 3; i++) begin
            tick;
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            n_tests++; if (ms2ws_bus[31:0] !== 32'h0000_9ABC) begin n_fail++; $display("FAIL hu_stall%0d got %h exp 00009abc", i, ms2ws_bus[31:0]); end
            n_tests++; if (ms2ws_valid !== 1'b1 || ms2ws_bus[69:38] !== 32'h104) begin n_fail++; $display("FAIL hu_hold%0d got %h/%h exp 1/104", i, ms2ws_valid, ms2ws_bus[69:38]); end
        end
        ws_allowin = 1'b1;
    endtask

    task automatic test_nonload;
        tick;
        es2ms_valid = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (ms2ws_bus[69:38] !== 32'h108) begin n_fail++; $display("FAIL add_pc got %h exp 108", ms2ws_bus[69:38]); end
        n_tests++; if (ms2ws_bus[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL add_result got %h exp 12345678", ms2ws_bus[31:0]); end
        n_tests++; if (ms2ws_valid !== 1'b1 || ms_res_from_mem !== 1'b0) begin n_fail++; $display("FAIL add_flags got %h/%h exp 1/0", ms2ws_valid, ms_res_from_mem); end
        tick;
    endtask

    task automatic test_align;
        logic [2:0]  ld  [7] = '{LD_H, LD_H, LD_BU, LD_B, LD_W, 3'd7, LD_HU};
        logic [1:0]  ad  [7] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
        logic [31:0] rd  [7] = '{32'h8001_0000, 32'h0000_7FFF, 32'h0000_A500, 32'h0000_007F,
                                 32'hDEAD_BEEF, 32'h1122_3344, 32'h1234_FFFF};
        logic [31:0] exp [7] = '{32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_00A5, 32'h0000_007F,
                                 32'hDEAD_BEEF, 32'h1122_3344, 32'h0000_FFFF};
        for (int i = 0; i < 7; i++) begin
            es2ms_valid = 1'b1; es2ms_bus = mk(32'h300 + i, 1'b1, 5'd1, 1'b1, ld[i], {28'h0000_400, 2'b00, ad[i]});
            tick;
            es2ms_valid = 1'b0; data_sram_rdata = rd[i];
            #1;
            n_tests++; if (ms2ws_bus[31:0] !== exp[i]) begin n_fail++; $display("FAIL align%0d got %h exp %h", i, ms2ws_bus[31:0], exp[i]); end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        es2ms_valid = 1'b1; es2ms_bus = mk(32'h200, 1'b1, 5'd2, 1'b0, LD_W, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            tick;
            n_tests++; if (ms2ws_bus[69:38] !== 32'h200 + 32'(4 * i) || ms2ws_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pc%0d got %h/%h exp %h/1", i, ms2ws_bus[69:38], ms2ws_valid, 32'h200 + 32'(4 * i)); end
            n_tests++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allowin%0d got %h exp 1", i, ms_allowin); end
            es2ms_bus = mk(32'h200 + 32'(4 * (i + 1)), 1'b1, 5'd2, 1'b0, LD_W, 32'hA0);
            es2ms_valid = i < 3;
        end
        tick;
    endtask

    task automatic test_reset_mid_stall;
        es2ms_valid = 1'b1; es2ms_bus = mk(32'h400, 1'b1, 5'd11, 1'b1, LD_W, 32'h0); ws_allowin = 1'b1;
        tick;
        es2ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_rdata = 32'h5555_AAAA;
        tick;
        n_tests++; if (ms_valid !== 1'b1 || ms2ws_bus[31:0] !== 32'h5555_AAAA) begin n_fail++; $display("FAIL prestall got %h/%h exp 1/5555aaaa", ms_valid, ms2ws_bus[31:0]); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        n_tests++; if (ms_valid !== 1'b0 || ms2ws_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid got %h/%h exp 0/0", ms_valid, ms2ws_valid); end
        n_tests++; if (ms_res_from_mem !== 1'b0 || gr_we_reg !== 1'b0) begin n_fail++; $display("FAIL rst_stall_flags got %h/%h exp 0/0", ms_res_from_mem, gr_we_reg); end
        ws_allowin = 1'b1;
        tick;
    endtask

`ifdef MEM_FWD_EN
    task automatic test_fwd;
        es2ms_valid = 1'b1; es2ms_bus = mk(32'h500, 1'b1, 5'd5, 1'b1, LD_W, 32'h0000_0010);
        tick;
        es2ms_valid = 1'b0; data_sram_rdata = 32'h0BAD_F00D;
        #1;
        n_tests++; if (ms_fwd_zip !== {1'b1, 5'd5, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL fwd_zip got %h exp %h", ms_fwd_zip, {1'b1, 5'd5, 32'h0BAD_F00D}); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_load_byte;
        test_stall_hold;
        test_nonload;
        test_align;
        test_back_to_back;
        test_reset_mid_stall;
`ifdef MEM_FWD_EN
        test_fwd;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
